// File: rtl/p_vector_writer.sv
// Packs a stream of elements into cluster words and writes one word per cluster
// to the P-vector memory, raising finish after the last cluster.
module p_vector_writer #(
    parameter int number_of_clusters              = 1,
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 32,
    parameter int address_width                   = 20
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic [element_width-1:0]                             in_data,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    output logic [number_of_equations_per_cluster*element_width-1:0] mem_input_data,
    output logic                                                 mem_write_enable,
    output logic [address_width-1:0]                             mem_write_address,
    output logic                                                 busy,
    output logic                                                 finish
);
    localparam int NE     = number_of_equations_per_cluster;
    localparam int EW     = element_width;
    localparam int WORD_W = NE * EW;
    localparam int ECNT_W = $clog2(NE + 1);
    localparam int CCNT_W = $clog2(number_of_clusters + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ECNT_W-1:0]   elem_q, elem_d;
    logic [CCNT_W-1:0]   clus_q, clus_d;
    logic [WORD_W-1:0]   pack_q, pack_d, pack_ins;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [address_width-1:0] addr_q, addr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            clus_q  <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            clus_q  <= clus_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Current packing register with the incoming element dropped into its lane.
    always_comb begin
        pack_ins = pack_q;
        for (int k = 0; k < NE; k++) begin
            if (elem_q == ECNT_W'(k)) pack_ins[k*EW +: EW] = in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        clus_d  = clus_q;
        pack_d  = pack_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    elem_d  = '0;
                    clus_d  = '0;
                    pack_d  = '0;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    pack_d = pack_ins;
                    elem_d = elem_q + ECNT_W'(1);
                    if (elem_q == ECNT_W'(NE - 1)) begin
                        data_d  = pack_ins;
                        addr_d  = address_width'(clus_q);
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                elem_d = '0;
                pack_d = '0;
                if (clus_q == CCNT_W'(number_of_clusters - 1)) begin
                    state_d = S_DONE;
                end else begin
                    clus_d  = clus_q + CCNT_W'(1);
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The strobe is exactly the single WRITE cycle, so it can never stretch.
    assign in_ready          = (state_q == S_COLLECT);
    assign mem_write_enable  = (state_q == S_WRITE);
    assign busy              = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign finish            = (state_q == S_DONE);
    assign mem_input_data    = data_q;
    assign mem_write_address = addr_q;
endmodule

// File: doc/p_vector_writer.md
Name: p_vector_writer

Overview:
- Write-side producer for the P-vector cluster memory.
- Accepts a stream of single elements over valid/ready and packs number_of_equations_per_cluster elements into one cluster word.
- Issues one write strobe per packed cluster to the memory's write port: data, write enable and write address.
- Asserts finish once all number_of_clusters words are written. It sits between the update datapath and the P memory.

Parameters:
number_of_clusters, 1, cluster words to write per run
number_of_equations_per_cluster, 9, elements packed per cluster word
element_width, 32, bits per element
address_width, 20, width of memory write address

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
in_data  input  element_width  element value
in_valid  input  1  in_data valid
in_ready  output  1  element accepted when in_valid && in_ready at clk edge
mem_input_data  output  number_of_equations_per_cluster*element_width  packed cluster word to memory
mem_write_enable  output  1  one-cycle write strobe
mem_write_address  output  address_width  cluster index being written
busy  output  1  high in COLLECT or WRITE
finish  output  1  high in DONE, held until next start or reset

Behaviour:
- Reset (async, immediate) clears every output and all state:
  - state=IDLE; in_ready=0, mem_write_enable=0, mem_input_data=0, mem_write_address=0, busy=0, finish=0.
  - Element and cluster counters are 0; the packing register is 0.
  - A reset in mid-run abandons the run. No partial word is written.
- FSM states:
  - IDLE: in_ready=0. start -> COLLECT, counters cleared.
  - COLLECT: in_ready=1. Each accepted element goes to lane element_count, bits [(k+1)*element_width-1 : k*element_width]; lane 0 is the LSBs. element_count then increments.
  - On the edge that accepts lane number_of_equations_per_cluster-1:
    - mem_input_data is registered with the full word, including this final element.
    - mem_write_address is registered with cluster_count, zero-extended.
    - mem_write_enable<=1 and state -> WRITE.
  - WRITE (exactly one cycle): in_ready=0 and mem_write_enable=1, so the memory captures at the end of this cycle. element_count and the packing register return to 0.
    - If cluster_count==number_of_clusters-1 -> DONE.
    - Otherwise cluster_count increments -> COLLECT.
  - DONE: finish=1, in_ready=0. start -> COLLECT with counters cleared and finish dropping on the same edge.
- Latency:
  - Write strobe is high in the cycle immediately after the last element of a cluster is accepted.
  - Minimum period is number_of_equations_per_cluster+1 cycles per cluster.
  - finish rises the cycle after the last WRITE cycle.
- mem_write_enable is never high for more than one consecutive cycle. mem_input_data and mem_write_address hold their last values after the strobe.
- start in COLLECT or WRITE is ignored.
- in_valid while in_ready=0: no acceptance and no state change. The upstream source must hold the element.
- Counters:
  - element_count is sized $clog2(number_of_equations_per_cluster+1).
  - cluster_count is sized $clog2(number_of_clusters+1).
  - Neither counter ever exceeds its limit; there is no wrap-around.
- number_of_clusters must be ≤ 2^address_width. With number_of_clusters=1, address is always 0.

Test Plan:
- Defaults; reset, start, then 9 consecutive valid elements 0x1..0x9 -> one mem_write_enable pulse the cycle after the 9th accept, address 0. mem_input_data = {0x9,...,0x1}, with 0x00000001 in bits[31:0]. finish=1 the next cycle and in_ready=0 during WRITE.
- number_of_clusters=3; stream 27 elements 0..26 with random in_valid gaps -> exactly 3 strobes at addresses 0,1,2. Lane data is correct; finish only after the 3rd; busy is high throughout; no acceptance during WRITE cycles.
- Assert reset after 5 elements of cluster 1 (clusters=3) -> outputs zero immediately, no strobe. A new start rewrites from address 0 with fresh lanes.
- start pulses in the middle of COLLECT -> ignored: counts, addresses and strobe count unchanged.
- In DONE, hold in_valid=1 for 10 cycles -> no acceptance, finish stays 1. Then pulse start -> finish=0 next cycle, and a second full run writes address 0 again.
- element_width=16, number_of_equations_per_cluster=4, address_width=4, clusters=2 -> 64-bit words. Address is zero-extended in 4 bits and packing order is LSB-first.
